// File: rtl/stack_controller.sv
// stack_controller: drives a single `memory` instance as a LIFO nibble stack.
// Accepts one PUSH/POP/PEEK/CLEAR command at a time over valid/ready and returns
// exactly one response per command over a second valid/ready pair.

`ifndef MEMORY_ADDR_BITS
`define MEMORY_ADDR_BITS 4
`endif
`ifndef MEMORY_MODE_NONE
`define MEMORY_MODE_NONE 2'd0
`endif
`ifndef MEMORY_MODE_READ
`define MEMORY_MODE_READ 2'd1
`endif
`ifndef MEMORY_MODE_WRITE
`define MEMORY_MODE_WRITE 2'd2
`endif
`ifndef MEMORY_MODE_CLEAR
`define MEMORY_MODE_CLEAR 2'd3
`endif

module stack_controller #(
  parameter int unsigned ADDR_BITS = `MEMORY_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [3:0]           cmd_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [3:0]           rsp_data,
  output logic                 rsp_err,
  output logic [ADDR_BITS:0]   depth,
  output logic                 full,
  output logic                 empty,
  output logic [1:0]           mem_mode,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [3:0]           mem_wdata,
  input  logic [3:0]           mem_rdata
);

  localparam logic [1:0] OpPush  = 2'd0;
  localparam logic [1:0] OpPop   = 2'd1;
  localparam logic [1:0] OpPeek  = 2'd2;
  localparam logic [1:0] OpClear = 2'd3;

  localparam logic [ADDR_BITS:0] SpOne = ADDR_BITS'(1);

  typedef enum logic [2:0] {StIdle, StWr, StRd, StCap, StClr, StResp} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_BITS:0]     sp_q, sp_d;
  logic                   pop_q, pop_d;
  logic [3:0]             rsp_data_q, rsp_data_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;
  logic [3:0]             mem_wdata_q, mem_wdata_d;
  logic [ADDR_BITS:0]     sp_m1;

  // Stack status is a pure function of the pointer; sp never exceeds 2**ADDR_BITS,
  // so the MSB alone marks a full stack.
  assign sp_m1     = sp_q - SpOne;
  assign depth     = sp_q;
  assign full      = sp_q[ADDR_BITS];
  assign empty     = (sp_q == '0);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Next-state, handshake and memory-mode decode.
  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    pop_d       = pop_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_mode    = `MEMORY_MODE_NONE;
    cmd_ready   = (state_q == StIdle);
    rsp_valid   = (state_q == StResp);

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          rsp_data_d = 4'h0;
          rsp_err_d  = 1'b0;
          unique case (cmd_op)
            OpPush: begin
              if (full) begin
                // Overflow: answer immediately, no memory access.
                rsp_err_d = 1'b1;
                state_d   = StResp;
              end else begin
                mem_addr_d  = sp_q[ADDR_BITS-1:0];
                mem_wdata_d = cmd_data;
                state_d     = StWr;
              end
            end
            OpPop, OpPeek: begin
              pop_d = (cmd_op == OpPop);
              if (empty) begin
                rsp_err_d = 1'b1;
                state_d   = StResp;
              end else begin
                mem_addr_d = sp_m1[ADDR_BITS-1:0];
                state_d    = StRd;
              end
            end
            OpClear: begin
              state_d = StClr;
            end
          endcase
        end
      end
      StWr: begin
        mem_mode = `MEMORY_MODE_WRITE;
        sp_d     = sp_q + SpOne;
        state_d  = StResp;
      end
      StRd: begin
        mem_mode = `MEMORY_MODE_READ;
        if (pop_q) sp_d = sp_m1;
        state_d  = StCap;
      end
      StCap: begin
        // Memory output is registered, so the read data is valid one cycle after RD.
        rsp_data_d = mem_rdata;
        state_d    = StResp;
      end
      StClr: begin
        mem_mode = `MEMORY_MODE_CLEAR;
        sp_d     = '0;
        state_d  = StResp;
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset aborts any command in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sp_q        <= '0;
      pop_q       <= 1'b0;
      rsp_data_q  <= 4'h0;
      rsp_err_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 4'h0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      pop_q       <= pop_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_stack_controller.sv
// Testbench for stack_controller with a behavioural memory and a response scoreboard.

`ifndef MEMORY_MODE_NONE
`define MEMORY_MODE_NONE 2'd0
`endif
`ifndef MEMORY_MODE_READ
`define MEMORY_MODE_READ 2'd1
`endif
`ifndef MEMORY_MODE_WRITE
`define MEMORY_MODE_WRITE 2'd2
`endif
`ifndef MEMORY_MODE_CLEAR
`define MEMORY_MODE_CLEAR 2'd3
`endif

module tb_stack_controller;

  localparam int unsigned ADDR_BITS = 4;
  localparam int CAP = 1 << ADDR_BITS;

  localparam logic [1:0] OP_PUSH  = 2'd0;
  localparam logic [1:0] OP_POP   = 2'd1;
  localparam logic [1:0] OP_PEEK  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [3:0]           cmd_data;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [3:0]           rsp_data;
  logic                 rsp_err;
  logic [ADDR_BITS:0]   depth;
  logic                 full;
  logic                 empty;
  logic [1:0]           mem_mode;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [3:0]           mem_wdata;
  logic [3:0]           mem_rdata = 4'h0;

  stack_controller #(.ADDR_BITS(ADDR_BITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .depth     (depth),
    .full      (full),
    .empty     (empty),
    .mem_mode  (mem_mode),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural memory: registered read, CLEAR zeroes data_out only.
  logic [3:0] mem [CAP];
  always @(posedge clk) begin
    case (mem_mode)
      `MEMORY_MODE_WRITE: mem[mem_addr] <= mem_wdata;
      `MEMORY_MODE_READ:  mem_rdata <= mem[mem_addr];
      `MEMORY_MODE_CLEAR: mem_rdata <= 4'h0;
      default: ;
    endcase
  end

  typedef struct {
    logic [3:0] data;
    logic       err;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] model[$];
  int         total = 0;
  int         bad = 0;

  int                   obs_lat;
  logic [3:0]           obs_data;
  logic                 obs_err;
  logic                 saw_write, saw_read;
  logic [ADDR_BITS-1:0] wr_addr, rd_addr;
  logic [3:0]           wr_data;
  int                   clr_cnt;

  // Issue one command, push its expected response, and wait for rsp_valid.
  task automatic do_cmd(input logic [1:0] op, input logic [3:0] d);
    exp_t e;
    bit   got;
    int   guard;
    @(negedge clk);
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      total++; bad++;
      $display("FAIL cmd_ready_wait: cmd_ready=%b required 1", cmd_ready);
    end
    e.data = 4'h0; e.err = 1'b0; e.lat = 2;
    case (op)
      OP_PUSH: begin
        if (model.size() == CAP) begin e.err = 1'b1; e.lat = 1; end
        else model.push_back(d);
      end
      OP_POP: begin
        if (model.size() == 0) begin e.err = 1'b1; e.lat = 1; end
        else begin e.data = model.pop_back(); e.lat = 3; end
      end
      OP_PEEK: begin
        if (model.size() == 0) begin e.err = 1'b1; e.lat = 1; end
        else begin e.data = model[model.size()-1]; e.lat = 3; end
      end
      default: model.delete();
    endcase
    sb.push_back(e);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    @(posedge clk);
    #1 cmd_valid = 1'b0; cmd_data = 4'h0;
    obs_lat = 0; saw_write = 0; saw_read = 0; clr_cnt = 0; got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      obs_lat++;
      if (mem_mode == `MEMORY_MODE_WRITE) begin saw_write = 1; wr_addr = mem_addr; wr_data = mem_wdata; end
      if (mem_mode == `MEMORY_MODE_READ) begin saw_read = 1; rd_addr = mem_addr; end
      if (mem_mode == `MEMORY_MODE_CLEAR) clr_cnt++;
      if (rsp_valid) begin got = 1; break; end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL rsp_wait: rsp_valid=%b required 1 within 10 cycles", rsp_valid);
    end
    obs_data = rsp_data;
    obs_err  = rsp_err;
  endtask

  // Complete the response handshake; returns just after the consuming edge.
  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 4'h0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      bad++; $display("FAIL reset_hs: ready/valid=%b required 10", {cmd_ready, rsp_valid});
    end
    total++;
    if (depth !== '0 || empty !== 1'b1 || full !== 1'b0) begin
      bad++; $display("FAIL reset_depth: depth=%0d empty=%b full=%b required 0 1 0", depth, empty, full);
    end
    total++;
    if (mem_mode !== `MEMORY_MODE_NONE || mem_addr !== '0 || mem_wdata !== 4'h0 ||
        rsp_data !== 4'h0 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL reset_pins: mode=%0d addr=%0d wdata=%h rdata=%h err=%b required all 0",
                      mem_mode, mem_addr, mem_wdata, rsp_data, rsp_err);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_push_basic();
    exp_t e;
    do_cmd(OP_PUSH, 4'hA);
    e = sb.pop_front();
    total++;
    if (obs_data !== e.data || obs_err !== e.err || obs_lat !== e.lat) begin
      bad++; $display("FAIL push_rsp: d=%h e=%b lat=%0d required d=%h e=%b lat=%0d",
                      obs_data, obs_err, obs_lat, e.data, e.err, e.lat);
    end
    total++;
    if (saw_write !== 1'b1 || wr_addr !== '0 || wr_data !== 4'hA) begin
      bad++; $display("FAIL push_write: seen=%b addr=%0d wdata=%h required 1 0 a", saw_write, wr_addr, wr_data);
    end
    finish_rsp();
    @(negedge clk);
    total++;
    if (int'(depth) !== model.size()) begin
      bad++; $display("FAIL push_depth: depth=%0d required %0d", depth, model.size());
    end
  endtask

  task automatic test_push_pop();
    logic [1:0] ops [5] = '{OP_PUSH, OP_PUSH, OP_POP, OP_POP, OP_POP};
    logic [3:0] dat [5] = '{4'h3, 4'h7, 4'h0, 4'h0, 4'h0};
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      do_cmd(ops[i], dat[i]);
      e = sb.pop_front();
      total++;
      if (obs_data !== e.data || obs_err !== e.err || obs_lat !== e.lat) begin
        bad++; $display("FAIL pushpop_rsp%0d: d=%h e=%b lat=%0d required d=%h e=%b lat=%0d",
                        i, obs_data, obs_err, obs_lat, e.data, e.err, e.lat);
      end
      finish_rsp();
      @(negedge clk);
      total++;
      if (int'(depth) !== model.size()) begin
        bad++; $display("FAIL pushpop_depth%0d: depth=%0d required %0d", i, depth, model.size());
      end
    end
    total++;
    if (empty !== 1'b1) begin
      bad++; $display("FAIL pushpop_empty: empty=%b required 1", empty);
    end
  endtask

  task automatic test_peek();
    logic [1:0] ops [4] = '{OP_PUSH, OP_PEEK, OP_PEEK, OP_POP};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      do_cmd(ops[i], 4'h5);
      e = sb.pop_front();
      total++;
      if (obs_data !== e.data || obs_err !== e.err || obs_lat !== e.lat) begin
        bad++; $display("FAIL peek_rsp%0d: d=%h e=%b lat=%0d required d=%h e=%b lat=%0d",
                        i, obs_data, obs_err, obs_lat, e.data, e.err, e.lat);
      end
      if (ops[i] == OP_PEEK) begin
        total++;
        if (saw_read !== 1'b1 || rd_addr !== '0) begin
          bad++; $display("FAIL peek_addr%0d: read=%b addr=%0d required 1 0", i, saw_read, rd_addr);
        end
      end
      finish_rsp();
      @(negedge clk);
      total++;
      if (int'(depth) !== model.size()) begin
        bad++; $display("FAIL peek_depth%0d: depth=%0d required %0d", i, depth, model.size());
      end
    end
  endtask

  task automatic test_full();
    exp_t       e;
    logic [3:0] v;
    for (int i = 0; i < CAP; i++) begin
      v = 4'(i) ^ 4'h5;
      do_cmd(OP_PUSH, v);
      e = sb.pop_front();
      total++;
      if (obs_err !== e.err || obs_lat !== e.lat) begin
        bad++; $display("FAIL fill_rsp%0d: e=%b lat=%0d required e=%b lat=%0d", i, obs_err, obs_lat, e.err, e.lat);
      end
      finish_rsp();
    end
    @(negedge clk);
    total++;
    if (full !== 1'b1 || int'(depth) !== CAP) begin
      bad++; $display("FAIL full_flag: full=%b depth=%0d required 1 %0d", full, depth, CAP);
    end
    do_cmd(OP_PUSH, 4'hF);
    e = sb.pop_front();
    total++;
    if (obs_data !== e.data || obs_err !== e.err || obs_lat !== e.lat || saw_write !== 1'b0) begin
      bad++; $display("FAIL overflow: d=%h e=%b lat=%0d wr=%b required d=%h e=%b lat=%0d wr=0",
                      obs_data, obs_err, obs_lat, saw_write, e.data, e.err, e.lat);
    end
    finish_rsp();
    do_cmd(OP_POP, 4'h0);
    e = sb.pop_front();
    total++;
    if (obs_data !== e.data || obs_err !== e.err || obs_lat !== e.lat) begin
      bad++; $display("FAIL full_pop: d=%h e=%b lat=%0d required d=%h e=%b lat=%0d",
                      obs_data, obs_err, obs_lat, e.data, e.err, e.lat);
    end
    finish_rsp();
    do_cmd(OP_CLEAR, 4'h0);
    e = sb.pop_front();
    total++;
    if (obs_err !== e.err || obs_lat !== e.lat) begin
      bad++; $display("FAIL full_clear: e=%b lat=%0d required e=%b lat=%0d", obs_err, obs_lat, e.err, e.lat);
    end
    finish_rsp();
  endtask

  task automatic test_underflow_hold();
    exp_t e;
    do_cmd(OP_POP, 4'h0);
    e = sb.pop_front();
    total++;
    if (obs_data !== e.data || obs_err !== e.err || obs_lat !== e.lat) begin
      bad++; $display("FAIL underflow: d=%h e=%b lat=%0d required d=%h e=%b lat=%0d",
                      obs_data, obs_err, obs_lat, e.data, e.err, e.lat);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_err !== e.err || rsp_data !== e.data) begin
        bad++; $display("FAIL hold%0d: valid=%b ready=%b e=%b d=%h required 1 0 %b %h",
                        i, rsp_valid, cmd_ready, rsp_err, rsp_data, e.err, e.data);
      end
    end
    finish_rsp();
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL hold_release: valid=%b ready=%b required 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_clear_reset();
    exp_t e;
    do_cmd(OP_PUSH, 4'h2);
    void'(sb.pop_front());
    finish_rsp();
    do_cmd(OP_CLEAR, 4'h0);
    e = sb.pop_front();
    total++;
    if (obs_err !== e.err || obs_lat !== e.lat || clr_cnt !== 1) begin
      bad++; $display("FAIL clear: e=%b lat=%0d clr_cycles=%0d required e=%b lat=%0d clr_cycles=1",
                      obs_err, obs_lat, clr_cnt, e.err, e.lat);
    end
    total++;
    if (depth !== '0 || empty !== 1'b1) begin
      bad++; $display("FAIL clear_depth: depth=%0d empty=%b required 0 1", depth, empty);
    end
    finish_rsp();
    do_cmd(OP_PUSH, 4'h9);
    void'(sb.pop_front());
    finish_rsp();
    // POP aborted by reset while the read is on the memory pins.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_POP;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    total++;
    if (mem_mode !== `MEMORY_MODE_READ) begin
      bad++; $display("FAIL abort_rd: mode=%0d required %0d", mem_mode, `MEMORY_MODE_READ);
    end
    rst_n = 1'b0;
    model.delete();
    #1;
    total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || depth !== '0 || mem_mode !== `MEMORY_MODE_NONE) begin
      bad++; $display("FAIL abort_state: valid=%b ready=%b depth=%0d mode=%0d required 0 1 0 0",
                      rsp_valid, cmd_ready, depth, mem_mode);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0) begin
        bad++; $display("FAIL abort_norsp%0d: rsp_valid=%b required 0", i, rsp_valid);
      end
    end
    do_cmd(OP_POP, 4'h0);
    e = sb.pop_front();
    total++;
    if (obs_data !== e.data || obs_err !== e.err || obs_lat !== e.lat) begin
      bad++; $display("FAIL abort_pop: d=%h e=%b lat=%0d required d=%h e=%b lat=%0d",
                      obs_data, obs_err, obs_lat, e.data, e.err, e.lat);
    end
    finish_rsp();
  endtask

  initial begin
    test_reset();
    test_push_basic();
    test_push_pop();
    test_peek();
    test_full();
    test_underflow_hold();
    test_clear_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
